// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the multicycle processor control unit.
// Contents: opcode constants, FSM state encoding, instruction-register
// field positions and small field-extraction helpers.
package proc_pkg;

  // Opcodes carried in IR[15:13]
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  // Instruction-register field positions
  localparam int unsigned IR_OP_HI = 15;
  localparam int unsigned IR_OP_LO = 13;
  localparam int unsigned IR_RX_HI = 12;
  localparam int unsigned IR_RX_LO = 10;
  localparam int unsigned IR_RY_HI = 9;
  localparam int unsigned IR_RY_LO = 7;

  // Register index of the program counter
  localparam logic [2:0] REG_PC = 3'd7;

  // Control FSM states: three fetch cycles, up to three execute cycles
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_F3   = 3'd3,
    S_E1   = 3'd4,
    S_E2   = 3'd5,
    S_E3   = 3'd6
  } state_t;

  function automatic logic [2:0] ir_op(input logic [15:0] ir);
    return ir[IR_OP_HI:IR_OP_LO];
  endfunction

  function automatic logic [2:0] ir_rx(input logic [15:0] ir);
    return ir[IR_RX_HI:IR_RX_LO];
  endfunction

  function automatic logic [2:0] ir_ry(input logic [15:0] ir);
    return ir[IR_RY_HI:IR_RY_LO];
  endfunction

endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-bit binary to one-hot 8-bit decoder with enable.
// Ports: sel_i - register index, en_i - enable, y_o - one-hot output
// (all zero when en_i is low).
module dec3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  // One-hot decode, forced to zero when disabled
  always_comb begin
    y_o = 8'h00;
    if (en_i) begin
      y_o = 8'h01 << sel_i;
    end else begin
      y_o = 8'h00;
    end
  end

endmodule

// File: rtl/proc_control.sv
// proc_control: multicycle control FSM for the 16-bit processor datapath.
// Fetches through R7 (PC), loads IR, then sequences register enables,
// the A/G accumulator pair, add/sub and memory address/data registers.
// Ports:
//   Clock, Resetn   - clock, asynchronous active-low reset
//   Run             - start/continue; sampled in IDLE and at Done
//   IR              - current instruction
//   Gnz             - G non-zero flag (used by mvnz in E1)
//   IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub,
//   ADDRin, DOUTin, W_D, Acress, Done - datapath control strobes,
//   combinational decodes of the registered state and IR.
module proc_control
  import proc_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] IR,
  input  logic        Gnz,
  output logic        IRin,
  output logic [7:0]  Rin,
  output logic [7:0]  Rout,
  output logic        Gout,
  output logic        DINout,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        ADDRin,
  output logic        DOUTin,
  output logic        W_D,
  output logic        Acress,
  output logic        Done
);

  state_t     state_q, state_d;
  logic [2:0] op_s, rx_s, ry_s;
  logic [2:0] rin_sel_s, rout_sel_s;
  logic       rin_en_s, rout_en_s;

  assign op_s = ir_op(IR);
  assign rx_s = ir_rx(IR);
  assign ry_s = ir_ry(IR);

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; short instructions finish in E1, the rest in E3
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_F1;
        else     state_d = S_IDLE;
      end
      S_F1: state_d = S_F2;
      S_F2: state_d = S_F3;
      S_F3: state_d = S_E1;
      S_E1: begin
        case (op_s)
          OP_MV, OP_MVNZ, OP_NOP: begin
            if (Run) state_d = S_F1;
            else     state_d = S_IDLE;
          end
          default: state_d = S_E2;
        endcase
      end
      S_E2: state_d = S_E3;
      S_E3: begin
        if (Run) state_d = S_F1;
        else     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of state and IR; register selects feed the decoders
  always_comb begin
    IRin       = 1'b0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    ADDRin     = 1'b0;
    DOUTin     = 1'b0;
    W_D        = 1'b0;
    Acress     = 1'b0;
    Done       = 1'b0;
    rin_sel_s  = 3'd0;
    rin_en_s   = 1'b0;
    rout_sel_s = 3'd0;
    rout_en_s  = 1'b0;
    case (state_q)
      S_F1: begin
        rout_sel_s = REG_PC;
        rout_en_s  = 1'b1;
        ADDRin     = 1'b1;
        Acress     = 1'b1;
      end
      S_F3: IRin = 1'b1;
      S_E1: begin
        case (op_s)
          OP_MV: begin
            rout_sel_s = ry_s; rout_en_s = 1'b1;
            rin_sel_s  = rx_s; rin_en_s  = 1'b1;
            Done       = 1'b1;
          end
          OP_MVI: begin
            rout_sel_s = REG_PC; rout_en_s = 1'b1;
            ADDRin     = 1'b1;
            Acress     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_sel_s = rx_s; rout_en_s = 1'b1;
            Ain        = 1'b1;
          end
          OP_LD, OP_ST: begin
            rout_sel_s = ry_s; rout_en_s = 1'b1;
            ADDRin     = 1'b1;
          end
          OP_MVNZ: begin
            // Gnz is used only here, combinationally
            if (Gnz) begin
              rout_sel_s = ry_s; rout_en_s = 1'b1;
              rin_sel_s  = rx_s; rin_en_s  = 1'b1;
            end else begin
              rout_en_s = 1'b0;
              rin_en_s  = 1'b0;
            end
            Done = 1'b1;
          end
          default: Done = 1'b1; // nop
        endcase
      end
      S_E2: begin
        case (op_s)
          OP_ADD, OP_SUB: begin
            rout_sel_s = ry_s; rout_en_s = 1'b1;
            Gin        = 1'b1;
            AddSub     = op_s[0];
          end
          OP_ST: begin
            rout_sel_s = rx_s; rout_en_s = 1'b1;
            DOUTin     = 1'b1;
          end
          default: begin
            // mvi/ld wait for memory read data
            rout_en_s = 1'b0;
          end
        endcase
      end
      S_E3: begin
        case (op_s)
          OP_MVI, OP_LD: begin
            DINout    = 1'b1;
            rin_sel_s = rx_s; rin_en_s = 1'b1;
            Done      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Gout      = 1'b1;
            rin_sel_s = rx_s; rin_en_s = 1'b1;
            Done      = 1'b1;
          end
          OP_ST: begin
            W_D  = 1'b1;
            Done = 1'b1;
          end
          default: Done = 1'b0;
        endcase
      end
      default: Done = 1'b0; // IDLE, F2: everything low
    endcase
  end

  dec3to8 u_rin_dec (
    .sel_i (rin_sel_s),
    .en_i  (rin_en_s),
    .y_o   (Rin)
  );

  dec3to8 u_rout_dec (
    .sel_i (rout_sel_s),
    .en_i  (rout_en_s),
    .y_o   (Rout)
  );

endmodule

// File: doc/proc_control.md
# proc_control

Multicycle control unit for the 16-bit processor datapath. It fetches each instruction through the R7 program counter (regc), loads the instruction register (regi), and sequences the general registers (regn), the A/G accumulator pair, the add/sub unit and the memory address/data registers over a shared bus. It is the only block that drives register load/output enables and PC increment.

## Interface
Parameters:
- none (widths fixed: 16-bit data, 8 registers, R7 = PC)

Ports:
- Clock  in  1  system clock, all state changes on rising edge
- Resetn  in  1  asynchronous, active-low reset
- Run  in  1  start/continue execution; sampled in IDLE and at Done
- IR  in  16  current instruction from the instruction register
- Gnz  in  1  G register non-zero flag from datapath
- IRin  out  1  load instruction register from DIN
- Rin  out  8  one-hot load enable for R0..R7
- Rout  out  8  one-hot bus drive for R0..R7
- Gout  out  1  G drives bus
- DINout  out  1  memory read data drives bus
- Ain  out  1  load A from bus
- Gin  out  1  load G with A ± bus
- AddSub  out  1  0 = add, 1 = subtract
- ADDRin  out  1  load address register from bus
- DOUTin  out  1  load write-data register from bus
- W_D  out  1  memory write strobe
- Acress  out  1  increment PC (R7)
- Done  out  1  one-cycle pulse in final cycle of each instruction

## Operation
- Instruction fields: IR[15:13] opcode, IR[12:10] rX, IR[9:7] rY, IR[6:0] ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 nop.
- States: IDLE, F1, F2, F3, E1, E2, E3.
- IDLE: all outputs 0; Run=1 → F1.
- F1: Rout[7], ADDRin, Acress → F2. F2: memory wait → F3. F3: IRin → E1.
- mv: E1 Rout[rY], Rin[rX], Done.
- mvi: E1 Rout[7], ADDRin, Acress; E2 wait; E3 DINout, Rin[rX], Done.
- add/sub: E1 Rout[rX], Ain; E2 Rout[rY], Gin, AddSub=opcode[0]; E3 Gout, Rin[rX], Done.
- ld: E1 Rout[rY], ADDRin; E2 wait; E3 DINout, Rin[rX], Done.
- st: E1 Rout[rY], ADDRin; E2 Rout[rX], DOUTin; E3 W_D, Done.
- mvnz: E1 if Gnz: Rout[rY], Rin[rX]; Done always.
- nop: E1 Done only.
- After Done: Run=1 → F1, else → IDLE.
- Invariants: at most one of Rout/Gout/DINout high per cycle; Acress and Rin[7] never high together.

## Timing
- Outputs are combinational decodes of state + IR; registered state only.
- Reset: state = IDLE immediately on Resetn low; every output 0 while reset held and in IDLE.
- Cycles per instruction including fetch: mv/mvnz/nop 4; mvi/add/sub/ld/st 6.
- Gnz sampled combinationally in E1 only.
- Run deasserted mid-instruction: instruction completes; FSM enters IDLE after Done.
- Resetn low mid-instruction: abort, no further enables; partial loads from prior edges stand.
- mv/ld/mvi with rX = 7 writes PC; next fetch uses the written value.

## Structure
- Package proc_pkg: opcode constants, state enum, IR field bit positions.
- Sub-module dec3to8: 3-bit to one-hot-8 decoder with enable, instantiated for Rin and Rout.

## Test plan
- Reset: Resetn low in E2 of add → all outputs 0 same cycle, state IDLE; release with Run=0 → stays IDLE.
- Fetch + mv R2←R5 (IR=16'h0A80) with Run=1 → F1 Rout=8'h80/ADDRin/Acress, F3 IRin, E1 Rout=8'h20 Rin=8'h04 Done; 4 cycles total.
- sub R1,R3 (IR=16'h6580) → E1 Rout=8'h02 Ain; E2 Rout=8'h08 Gin AddSub=1; E3 Gout Rin=8'h02 Done.
- st R4→[R6] (IR=16'hB300) → E1 Rout=8'h40 ADDRin; E2 Rout=8'h10 DOUTin; E3 W_D Done, no Rin.
- mvnz R0←R1 with Gnz=0 then Gnz=1 → first E1 Rin=0 Done=1; second Rout=8'h02 Rin=8'h01 Done=1.
- Run dropped during E2 of mvi → E3 completes with DINout Rin[rX] Done, then IDLE, no F1.
